// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment scan: debounces each (seg, dig_en)
// pair, assembles four-digit frames and publishes a frame once it repeats CONFIRM times.
module seg_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int CONFIRM = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_en,
    output logic [15:0] bcd_out,
    output logic        valid,
    output logic        err
);

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
    localparam logic [3:0] CONFIRM_C = 4'(CONFIRM);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    function automatic logic [3:0] decode_seg(input logic [6:0] s);
        logic [3:0] d;
        case (s)
            7'h3F:   d = 4'h0;
            7'h06:   d = 4'h1;
            7'h5B:   d = 4'h2;
            7'h4F:   d = 4'h3;
            7'h66:   d = 4'h4;
            7'h6D:   d = 4'h5;
            7'h7D:   d = 4'h6;
            7'h07:   d = 4'h7;
            7'h7F:   d = 4'h8;
            7'h6F:   d = 4'h9;
            7'h00:   d = 4'hF;
            default: d = 4'hE;
        endcase
        return d;
    endfunction

    function automatic logic has_invalid(input logic [15:0] f);
        return (f[3:0] == 4'hE) || (f[7:4] == 4'hE) || (f[11:8] == 4'hE) || (f[15:12] == 4'hE);
    endfunction

    state_t      state_r, state_n;
    logic [6:0]  seg_r, seg_p_r;
    logic [3:0]  dig_r, dig_p_r;
    logic [7:0]  cnt_r, cnt_n;
    logic [15:0] shadow_r, frame_s;
    logic [3:0]  mask_r, mask_n_s;
    logic [15:0] cand_r, cand_n;
    logic [3:0]  mcnt_r, mcnt_n;
    logic        load_pend_r, fire_s;
    logic [15:0] bcd_r;
    logic        valid_r, err_r;
    logic        onehot_s, changed_s, capture_s, complete_s;
    logic [3:0]  dec_s;

    assign onehot_s  = (dig_r == 4'b0001) || (dig_r == 4'b0010) ||
                       (dig_r == 4'b0100) || (dig_r == 4'b1000);
    assign changed_s = (seg_r != seg_p_r) || (dig_r != dig_p_r);
    assign dec_s     = decode_seg(seg_r);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Stability tracking: a capture fires on the SETTLE-th identical registered cycle
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (onehot_s) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 8'd1;
                end else begin
                    cnt_n   = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (changed_s) begin
                    cnt_n   = 8'd1;
                    state_n = onehot_s ? ST_SETTLE : ST_IDLE;
                end else if ((cnt_r + 8'd1) == SETTLE_C) begin
                    cnt_n     = SETTLE_C;
                    capture_s = 1'b1;
                    state_n   = ST_HELD;
                end else begin
                    cnt_n = cnt_r + 8'd1;
                end
            end
            ST_HELD: begin
                if (changed_s) begin
                    cnt_n   = 8'd1;
                    state_n = onehot_s ? ST_SETTLE : ST_IDLE;
                end else begin
                    state_n = ST_HELD;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // Frame assembly and candidate/match bookkeeping
    always_comb begin
        frame_s = shadow_r;
        case (dig_r)
            4'b0001: frame_s[3:0]   = dec_s;
            4'b0010: frame_s[7:4]   = dec_s;
            4'b0100: frame_s[11:8]  = dec_s;
            4'b1000: frame_s[15:12] = dec_s;
            default: frame_s = shadow_r;
        endcase
        mask_n_s   = mask_r | dig_r;
        complete_s = capture_s && (mask_n_s == 4'b1111);
        cand_n     = cand_r;
        mcnt_n     = mcnt_r;
        fire_s     = 1'b0;
        if (complete_s) begin
            if (has_invalid(frame_s)) begin
                mcnt_n = 4'd0;
            end else if (frame_s == cand_r) begin
                mcnt_n = (mcnt_r < CONFIRM_C) ? (mcnt_r + 4'd1) : mcnt_r;
            end else begin
                cand_n = frame_s;
                mcnt_n = 4'd1;
            end
            // A fresh candidate counts as a transition so CONFIRM=1 still publishes it
            fire_s = (mcnt_n == CONFIRM_C) && ((mcnt_r != CONFIRM_C) || (cand_n != cand_r));
        end else begin
            fire_s = 1'b0;
        end
    end

    // Input stage, shadow slots and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r       <= 7'd0;
            dig_r       <= 4'd0;
            seg_p_r     <= 7'd0;
            dig_p_r     <= 4'd0;
            shadow_r    <= 16'h0000;
            mask_r      <= 4'd0;
            cand_r      <= 16'h0000;
            mcnt_r      <= 4'd0;
            load_pend_r <= 1'b0;
            bcd_r       <= 16'h0000;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            seg_r       <= seg;
            dig_r       <= dig_en;
            seg_p_r     <= seg_r;
            dig_p_r     <= dig_r;
            if (capture_s) begin
                shadow_r <= frame_s;
                mask_r   <= complete_s ? 4'd0 : mask_n_s;
            end else begin
                shadow_r <= shadow_r;
                mask_r   <= mask_r;
            end
            cand_r      <= cand_n;
            mcnt_r      <= mcnt_n;
            load_pend_r <= fire_s;
            valid_r     <= load_pend_r;
            bcd_r       <= load_pend_r ? cand_r : bcd_r;
            err_r       <= capture_s && (dec_s == 4'hE);
        end
    end

    assign bcd_out = bcd_r;
    assign valid   = valid_r;
    assign err     = err_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a frame-level model pushes expected published
// frames and error counts; a negedge monitor pops and compares as the DUT reports them.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'd0;
    logic [3:0]  dig_en = 4'd0;
    logic [15:0] bcd_out;
    logic        valid;
    logic        err;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_cand = 16'h0000;
    int          m_cnt = 0;
    logic [15:0] m_out = 16'h0000;

    localparam int CONF = 2;

    seg_scan_decoder #(.SETTLE(4), .CONFIRM(CONF)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en),
        .bcd_out(bcd_out), .valid(valid), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hE: return 7'h49;
            default: return 7'h00;
        endcase
    endfunction

    // Monitor: pop an expected frame on every valid pulse, count err pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: bcd_out=%h, no publish expected", bcd_out);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (bcd_out !== e) begin
                        bad++;
                        $display("FAIL valid_value: bcd_out=%h expected=%h", bcd_out, e);
                    end
                end
            end
            if (err) err_seen++;
        end
    end

    task automatic model_frame(input logic [15:0] f);
        logic inv;
        logic [15:0] old_cand;
        int old_cnt;
        inv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (f[i*4 +: 4] == 4'hE) begin
                inv = 1'b1;
                err_exp++;
            end
        end
        old_cand = m_cand;
        old_cnt  = m_cnt;
        if (inv) m_cnt = 0;
        else if (f == m_cand) m_cnt = (m_cnt < CONF) ? m_cnt + 1 : m_cnt;
        else begin
            m_cand = f;
            m_cnt  = 1;
        end
        if (!inv && m_cnt == CONF && (old_cnt != CONF || old_cand != m_cand)) begin
            exp_q.push_back(m_cand);
            m_out = m_cand;
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
        seg = s;
        dig_en = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] f, input int hold, input int gap, input logic model);
        if (model) model_frame(f);
        for (int i = 0; i < 4; i++) begin
            drive(seg_of(f[i*4 +: 4]), 4'(1 << i), hold);
            if (gap > 0) drive(7'h00, 4'b0000, gap);
        end
    endtask

    task automatic finish_test(input string name);
        drive(7'h00, 4'b0000, 10);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_valid: pending=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
        total++;
        if (err_seen != err_exp) begin
            bad++;
            $display("FAIL %s_err_count: seen=%0d expected=%0d", name, err_seen, err_exp);
        end
        err_seen = 0;
        err_exp  = 0;
        total++;
        if (bcd_out !== m_out) begin
            bad++;
            $display("FAIL %s_bcd_out: got=%h expected=%h", name, bcd_out, m_out);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (bcd_out !== 16'h0000 || valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s: bcd_out=%h valid=%b err=%b expected 0000/0/0", name, bcd_out, valid, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        drive(7'h00, 4'b0000, 2);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_basic_scan();
        for (int k = 0; k < 3; k++) send_frame(16'h1234, 8, 0, 1'b1);
        finish_test("basic_scan");
    endtask

    task automatic test_short_hold();
        for (int k = 0; k < 2; k++) send_frame(16'h5678, 3, 0, 1'b0);
        finish_test("short_hold");
    endtask

    task automatic test_invalid();
        send_frame(16'h1E34, 8, 0, 1'b1);
        send_frame(16'h1234, 8, 0, 1'b1);
        send_frame(16'h1234, 8, 0, 1'b1);
        finish_test("invalid_segment");
    endtask

    task automatic test_blank();
        send_frame(16'hF059, 8, 0, 1'b1);
        send_frame(16'hF059, 8, 0, 1'b1);
        finish_test("blank_digit");
    endtask

    task automatic test_multi_hot_gaps();
        for (int k = 0; k < 2; k++) begin
            drive(7'h7F, 4'b0011, 20);
            send_frame(16'h9876, 8, 3, 1'b1);
        end
        finish_test("multi_hot_gaps");
    endtask

    task automatic test_reset_mid_frame();
        drive(seg_of(4'h1), 4'b0001, 8);
        drive(seg_of(4'h2), 4'b0010, 8);
        drive(seg_of(4'h3), 4'b0100, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_frame_reset");
        rst = 1'b0;
        m_cand = 16'h0000;
        m_cnt  = 0;
        m_out  = 16'h0000;
        exp_q.delete();
        err_seen = 0;
        err_exp  = 0;
        drive(7'h00, 4'b0000, 2);
        send_frame(16'h7777, 8, 0, 1'b1);
        send_frame(16'h7777, 8, 0, 1'b1);
        finish_test("reset_mid_frame");
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_short_hold();
        test_invalid();
        test_blank();
        test_multi_hot_gaps();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4: consecutive cycles a registered (seg, dig_en) pair must hold before capture; range 2..255.
REQ-002 SHALL have parameter CONFIRM, default 2: consecutive identical valid frames required before output update; range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port seg, input, 7 bits: active-high segment lines, bit0=a .. bit6=g, synchronous to clk.
REQ-006 SHALL have port dig_en, input, 4 bits: active-high digit select, one-hot when a digit is driven.
REQ-007 SHALL have port bcd_out, output, 16 bits: confirmed digits; [3:0]=digit of dig_en[0] .. [15:12]=digit of dig_en[3].
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse when bcd_out is updated.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse on capture of an invalid segment pattern.

Function
REQ-010 SHALL register seg and dig_en once (one input stage) before all other logic.
REQ-011 SHALL decode: 7'h3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 00->4'hF (blank); all other patterns->4'hE (invalid).
REQ-012 SHALL implement FSM IDLE, SETTLE, HELD; reset state IDLE.
REQ-013 IDLE: registered dig_en one-hot -> SETTLE with stable counter=1; otherwise stay.
REQ-014 SETTLE: registered seg or dig_en differs from previous cycle -> counter=1 (stay SETTLE if dig_en still one-hot, else IDLE); unchanged -> counter+1.
REQ-015 SETTLE: counter reaching SETTLE -> capture decoded digit into shadow slot of the selected digit, set its mask bit, go HELD.
REQ-016 HELD: no further capture; any change of registered seg or dig_en -> as REQ-014 (re-enter SETTLE or IDLE).
REQ-017 dig_en zero or with more than one bit set SHALL never capture; it SHALL be treated as IDLE.
REQ-018 Re-capture of an already-masked digit SHALL overwrite its shadow slot; mask unchanged.
REQ-019 Frame complete = capture that makes mask 4'b1111; mask SHALL clear on the same edge.
REQ-020 On frame complete with no invalid digit: frame equal to candidate -> match count +1, saturating at CONFIRM; otherwise candidate=frame, count=1.
REQ-021 On frame complete containing any 4'hE digit: match count=0, candidate unchanged.
REQ-022 When match count becomes CONFIRM (transition only), bcd_out SHALL load candidate and valid SHALL pulse on the following cycle, together with the bcd_out update.
REQ-023 A saturated count SHALL produce no further valid pulses until the candidate changes.
REQ-024 err SHALL pulse the cycle after any capture decoding to 4'hE, independent of frame state.
REQ-025 With CONFIRM=1, every frame differing from the candidate SHALL update bcd_out.

Reset
REQ-026 rst SHALL set bcd_out=16'h0000, valid=0, err=0, FSM=IDLE, counters=0, mask=0, candidate=0, match count=0.
REQ-027 rst mid-frame SHALL discard partial frame and pending valid/err; it takes precedence over all events on the same edge.

Verification
REQ-028 Scan digits 4,3,2,1 on dig_en[0..3], 8 cycles each, SETTLE=4, CONFIRM=2, three frames -> exactly one valid pulse, after frame 2, bcd_out=16'h1234; no pulse on frame 3.
REQ-029 Each digit held 3 cycles (SETTLE=4) -> no captures, no valid, no err.
REQ-030 Frame with 7'h49 on dig_en[2] -> err pulse once; no valid; next two clean frames required before valid.
REQ-031 Digits 9,5,0,blank (7'h00 on dig_en[3]), two frames -> bcd_out=16'hF059, valid once.
REQ-032 dig_en=4'b0011 held 20 cycles and dig_en=0 gaps between digits -> no capture from 0011; gaps do not break frame assembly.
REQ-033 rst after 3 digits captured, then two full frames of 7,7,7,7 -> bcd_out=0 during reset; valid after second post-reset frame, bcd_out=16'h7777.
